// File: rtl/sram_packet_loader_if.sv
// sram_packet_loader_if: core-side write port and read return of the SRAM packet loader
// Signals: wr_valid/wr_ready/wr_sel/wr_data carry 32-bit words from the core,
//          rd_valid/rd_data return the captured SRAM read word.
// Modports: master = management core, slave = loader.
interface sram_packet_loader_if;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    modport master (output wr_valid, wr_sel, wr_data, input wr_ready, rd_valid, rd_data);
    modport slave  (input wr_valid, wr_sel, wr_data, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/sram_packet_loader.sv
// sram_packet_loader: assembles two core words into a 55-bit SRAM packet, issues it, captures the read word
// Ports: clk_in clock; rst sync active-low reset; bus write port and read return (slave);
//        packet/chip_select drive the SRAM packetiser; rd_data_in is the SRAM output mux word;
//        busy is high outside IDLE; txn_count counts completed transactions (wraps).
module sram_packet_loader #(
    parameter int READ_LATENCY = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    sram_packet_loader_if.slave  bus,
    output logic [54:0]          packet,
    output logic                 chip_select,
    input  logic [31:0]          rd_data_in,
    output logic                 busy,
    output logic [CNT_W-1:0]     txn_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
    localparam logic [54:0] IDLE_PKT = 55'h60_0000_0000_0100;
    localparam logic [3:0]  LAT_M1   = 4'(READ_LATENCY - 1);
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      lo_q, lo_d;
    // hi word keeps only bit 31 (chip select) and bits 22:0; bits 30:23 are don't-care
    logic [23:0]      hi_q, hi_d;
    logic [54:0]      packet_q, packet_d;
    logic             cs_q, cs_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        rd_data_d = rd_data_q;
        txn_d     = txn_q;
        case (state_q)
            IDLE: begin
                if (bus.wr_valid && bus.wr_sel) begin
                    hi_d    = {bus.wr_data[31], bus.wr_data[22:0]};
                    state_d = ISSUE;
                end else if (bus.wr_valid) begin
                    lo_d = bus.wr_data;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = (READ_LATENCY == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                rd_data_d = rd_data_in;
                txn_d     = txn_q + CNT_W'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they change on the edge entering it
        packet_d   = (state_d == ISSUE) ? {hi_d[22:0], lo_d} : IDLE_PKT;
        cs_d       = (state_d == ISSUE) ? hi_d[23] : cs_q;
        rd_valid_d = (state_q == CAPTURE);
    end
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            packet_q   <= IDLE_PKT;
            cs_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            txn_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            packet_q   <= packet_d;
            cs_q       <= cs_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            txn_q      <= txn_d;
        end
    end
    assign bus.wr_ready = (state_q == IDLE);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign packet       = packet_q;
    assign chip_select  = cs_q;
    assign busy         = (state_q != IDLE);
    assign txn_count    = txn_q;
endmodule

// File: tb/tb_sram_packet_loader.sv
// tb_sram_packet_loader: directed self-checking bench for sram_packet_loader
module tb_sram_packet_loader;
    localparam logic [54:0] IDLE_PKT = 55'h60_0000_0000_0100;
    logic        clk = 1'b0;
    logic        rst, wr_valid, wr_sel;
    logic [31:0] wr_data, rd_data_in;
    int          passed = 0, total = 0;
    int          nw = 0, n1 = 0, iss_w = -1, iss_1 = -1, lat_w = -1, lat_1 = -1;
    always #5 clk = ~clk;
    sram_packet_loader_if ia(), iw(), i1();
    assign ia.wr_valid = wr_valid;
    assign ia.wr_sel   = wr_sel;
    assign ia.wr_data  = wr_data;
    assign iw.wr_valid = wr_valid;
    assign iw.wr_sel   = wr_sel;
    assign iw.wr_data  = wr_data;
    assign i1.wr_valid = wr_valid;
    assign i1.wr_sel   = wr_sel;
    assign i1.wr_data  = wr_data;
    logic [54:0] pkt_a, pkt_w, pkt_1;
    logic        cs_a, cs_w, cs_1, busy_a, busy_w, busy_1;
    logic [15:0] txn_a;
    logic [3:0]  txn_w, txn_1;
    sram_packet_loader #(.READ_LATENCY(4), .CNT_W(16)) dut_a (
        .clk_in(clk), .rst(rst), .bus(ia), .packet(pkt_a), .chip_select(cs_a),
        .rd_data_in(rd_data_in), .busy(busy_a), .txn_count(txn_a));
    sram_packet_loader #(.READ_LATENCY(4), .CNT_W(4)) dut_w (
        .clk_in(clk), .rst(rst), .bus(iw), .packet(pkt_w), .chip_select(cs_w),
        .rd_data_in(rd_data_in), .busy(busy_w), .txn_count(txn_w));
    sram_packet_loader #(.READ_LATENCY(1), .CNT_W(4)) dut_1 (
        .clk_in(clk), .rst(rst), .bus(i1), .packet(pkt_1), .chip_select(cs_1),
        .rd_data_in(rd_data_in), .busy(busy_1), .txn_count(txn_1));
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0; rd_data_in = '0;
        repeat (3) step;
        rst = 1'b1;
        step;
        chk("rst_pkt", pkt_a, IDLE_PKT);
        chk("rst_cs", cs_a, 0);
        chk("rst_ready", ia.wr_ready, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_txn", txn_a, 0);
        chk("rst_rdv", ia.rd_valid, 0);
        chk("rst_rdd", ia.rd_data, 0);
        wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 32'h0000_1234;
        step;
        chk("lo_stays_idle", busy_a, 0);
        wr_sel = 1'b1; wr_data = 32'h0000_0012;
        step;
        wr_valid = 1'b0;
        chk("w0_pkt", pkt_a, {23'h12, 32'h1234});
        chk("w0_cs", cs_a, 0);
        chk("w0_ready", ia.wr_ready, 0);
        step;
        chk("w0_pkt_idle", pkt_a, IDLE_PKT);
        repeat (4) step;
        chk("w0_rdv", ia.rd_valid, 1);
        chk("w0_txn", txn_a, 1);
        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 32'hFF80_0034; rd_data_in = 32'h1111_1111;
        step;
        wr_valid = 1'b0;
        chk("r1_pkt", pkt_a, {23'h34, 32'h1234});
        chk("r1_cs", cs_a, 1);
        for (int k = 0; k < 3; k++) begin
            step;
            chk("r1_wait_cs", cs_a, 1);
            chk("r1_wait_pkt", pkt_a, IDLE_PKT);
        end
        step;
        chk("r1_cap_rdv", ia.rd_valid, 0);
        rd_data_in = 32'hDEAD_BEEF;
        step;
        rd_data_in = 32'h1111_1111;
        chk("r1_rdv", ia.rd_valid, 1);
        chk("r1_rdd", ia.rd_data, 32'hDEAD_BEEF);
        chk("r1_txn", txn_a, 2);
        step;
        chk("r1_rdv_once", ia.rd_valid, 0);
        chk("r1_rdd_hold", ia.rd_data, 32'hDEAD_BEEF);
        chk("r1_cs_hold_idle", cs_a, 1);
        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 32'h0000_0056;
        step;
        chk("bp_pkt0", pkt_a, {23'h56, 32'h1234});
        chk("bp_cs0", cs_a, 0);
        wr_sel = 1'b0; wr_data = 32'hFFFF_FFFF;
        for (int k = 1; k <= 5; k++) begin
            step;
            chk("bp_pkt_idle", pkt_a, IDLE_PKT);
            chk("bp_ready", ia.wr_ready, 64'(k == 5));
        end
        wr_sel = 1'b1; wr_data = 32'h0000_0078;
        step;
        wr_valid = 1'b0;
        chk("bp_pkt1", pkt_a, {23'h78, 32'h1234});
        repeat (5) step;
        chk("bp_rdv", ia.rd_valid, 1);
        chk("bp_txn", txn_a, 4);
        rst = 1'b0;
        step;
        rst = 1'b1;
        chk("rst2_txn", txn_a, 0);
        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 32'h8000_0099;
        step;
        wr_valid = 1'b0; rd_data_in = 32'hCAFE_F00D;
        chk("ab_pkt", pkt_a, {23'h99, 32'h0});
        repeat (2) step;
        rst = 1'b0;
        step;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step;
            chk("abort_rdv", ia.rd_valid, 0);
        end
        chk("abort_rdd", ia.rd_data, 0);
        chk("abort_pkt", pkt_a, IDLE_PKT);
        chk("abort_txn", txn_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_cs", cs_a, 0);
        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 32'h0000_0001;
        step;
        wr_valid = 1'b0;
        chk("lo_rst_pkt", pkt_a, {23'h1, 32'h0});
        repeat (5) step;
        chk("lo_rst_rdv", ia.rd_valid, 1);
        chk("lo_rst_rdd", ia.rd_data, 32'hCAFE_F00D);
        chk("lo_rst_txn", txn_a, 1);
        rst = 1'b0;
        step;
        rst = 1'b1;
        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 32'h0000_0042;
        for (int k = 0; k < 300 && (nw < 17 || n1 < 17); k++) begin
            step;
            if (pkt_1 !== IDLE_PKT && iss_1 < 0) iss_1 = k;
            if (pkt_w !== IDLE_PKT && iss_w < 0) iss_w = k;
            if (i1.rd_valid) begin
                n1++;
                if (n1 == 1) lat_1 = k - iss_1;
                if (n1 == 16) chk("wrap16_rl1", txn_1, 0);
                if (n1 == 17) chk("wrap17_rl1", txn_1, 1);
            end
            if (iw.rd_valid) begin
                nw++;
                if (nw == 1) lat_w = k - iss_w;
                if (nw == 16) chk("wrap16_rl4", txn_w, 0);
                if (nw == 17) chk("wrap17_rl4", txn_w, 1);
            end
        end
        wr_valid = 1'b0;
        chk("wrap_done_rl1", 64'(n1 >= 17), 1);
        chk("wrap_done_rl4", 64'(nw >= 17), 1);
        chk("lat_rl1", 64'(lat_1), 2);
        chk("lat_rl4", 64'(lat_w), 5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
